gcn_aggregation: RTL

Downstream stage of the GCN datapath. It consumes the FEATURE_ROWS x WEIGHT_COLS feature-times-weight product matrix from the transformation stage. It walks the COO adjacency list one edge per cycle to form neighbourhood sums, then emits a per-node argmax class index on `max_addi_answer`. It owns the `coo_address` / `coo_in` fetch interface and the final `done` of the GCN top.

---
 rtl/gcn_pkg.sv | 38 +++
 rtl/gcn_row_argmax.sv | 26 ++
 rtl/gcn_aggregation.sv | 114 +++++++++++
 3 files changed

// File: rtl/gcn_pkg.sv
// Shared parameters, types and FSM encoding for the GCN aggregation stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gcn_pkg;

    localparam int FEATURE_ROWS      = 6;
    localparam int WEIGHT_COLS       = 3;
    localparam int DOT_PROD_WIDTH    = 16;
    localparam int NUM_OF_NODES      = 6;
    localparam int COO_NUM_OF_COLS   = 6;
    localparam int COO_BW            = $clog2(COO_NUM_OF_COLS);
    localparam int MAX_ADDRESS_WIDTH = $clog2(WEIGHT_COLS);
    localparam int NODE_CNT_W        = $clog2(FEATURE_ROWS);

    typedef logic [DOT_PROD_WIDTH-1:0]    elem_t;
    typedef elem_t [WEIGHT_COLS-1:0]      row_t;
    typedef logic [MAX_ADDRESS_WIDTH-1:0] cls_t;
    typedef logic [COO_BW-1:0]            node_id_t;
    typedef logic [NODE_CNT_W-1:0]        node_cnt_t;

    localparam node_id_t  MAX_NODE_ID = node_id_t'(NUM_OF_NODES);
    localparam node_id_t  LAST_EDGE   = node_id_t'(COO_NUM_OF_COLS - 1);
    localparam node_cnt_t LAST_NODE   = node_cnt_t'(FEATURE_ROWS - 1);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        EDGE,
        ARGMAX,
        DONE
    } agg_state_t;

    // Node ids are 1-based; 0 and anything past the node count mark a dead edge.
    function automatic logic node_id_ok(input node_id_t id);
        return (id != '0) && (id <= MAX_NODE_ID);
    endfunction

endpackage

// File: rtl/gcn_row_argmax.sv
// Combinational argmax over one product-matrix row, lowest index wins ties.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: row (WEIGHT_COLS unsigned elements) -> idx (class index of the maximum).
module gcn_row_argmax
    import gcn_pkg::*;
(
    input  row_t row,
    output cls_t idx
);

    elem_t best;

    always_comb begin
        best = row[0];
        idx  = '0;
        // Strict greater-than keeps the earliest column on equal values.
        for (int c = 1; c < WEIGHT_COLS; c++) begin
            if (row[c] > best) begin
                best = row[c];
                idx  = cls_t'(c);
            end
        end
    end

endmodule

// File: rtl/gcn_aggregation.sv
// GCN aggregation: neighbourhood sums over the COO edge list, then per-node argmax.
// Latency: done rises 2 + COO_NUM_OF_COLS + FEATURE_ROWS edges after start is sampled in IDLE.
// Backpressure: none; start is a level handshake, done holds until start drops.
// Ports: clk, reset (async active-low), start, fm_wm_in (product matrix),
//        coo_in/coo_address (edge fetch), max_addi_answer (class per node), done.
module gcn_aggregation
    import gcn_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  row_t [FEATURE_ROWS-1:0]        fm_wm_in,
    input  logic [2*COO_BW-1:0]            coo_in,
    output logic [COO_BW-1:0]              coo_address,
    output cls_t [FEATURE_ROWS-1:0]        max_addi_answer,
    output logic                           done
);

    agg_state_t state, state_nxt;

    row_t [FEATURE_ROWS-1:0] x_mat;
    row_t [FEATURE_ROWS-1:0] acc;
    row_t [FEATURE_ROWS-1:0] acc_upd;
    node_cnt_t               node_cnt;

    node_id_t src;
    node_id_t dst;
    logic     edge_ok;
    row_t     x_src;
    row_t     x_dst;
    cls_t     row_idx;

    assign src     = coo_in[2*COO_BW-1:COO_BW];
    assign dst     = coo_in[COO_BW-1:0];
    assign edge_ok = node_id_ok(src) && node_id_ok(dst);

    // Row select by 1-based id; an invalid id selects nothing (zero row).
    always_comb begin
        x_src = '0;
        x_dst = '0;
        for (int r = 0; r < FEATURE_ROWS; r++) begin
            if (src == node_id_t'(r + 1)) x_src = x_mat[r];
            if (dst == node_id_t'(r + 1)) x_dst = x_mat[r];
        end
    end

    // Undirected update from the frozen X copy; a self-loop edge adds its row once.
    always_comb begin
        acc_upd = acc;
        for (int r = 0; r < FEATURE_ROWS; r++) begin
            for (int c = 0; c < WEIGHT_COLS; c++) begin
                if (edge_ok && (src == node_id_t'(r + 1)))
                    acc_upd[r][c] = acc_upd[r][c] + x_dst[c];
                if (edge_ok && (dst == node_id_t'(r + 1)) && (src != dst))
                    acc_upd[r][c] = acc_upd[r][c] + x_src[c];
            end
        end
    end

    gcn_row_argmax u_row_argmax (
        .row (acc[node_cnt]),
        .idx (row_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = INIT;
            INIT:    state_nxt = EDGE;
            EDGE:    if (coo_address == LAST_EDGE) state_nxt = ARGMAX;
            ARGMAX:  if (node_cnt == LAST_NODE) state_nxt = DONE;
            DONE:    if (!start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_mat           <= '0;
            acc             <= '0;
            coo_address     <= '0;
            node_cnt        <= '0;
            max_addi_answer <= '0;
            done            <= 1'b0;
        end else begin
            // done follows DONE one edge late and drops on the edge that sees start low.
            done <= (state == DONE) && start;
            case (state)
                INIT: begin
                    x_mat           <= fm_wm_in;
                    acc             <= fm_wm_in;
                    coo_address     <= '0;
                    node_cnt        <= '0;
                    max_addi_answer <= '0;
                end
                EDGE: begin
                    acc         <= acc_upd;
                    coo_address <= (coo_address == LAST_EDGE) ? '0 : coo_address + 1'b1;
                end
                ARGMAX: begin
                    max_addi_answer[node_cnt] <= row_idx;
                    node_cnt <= (node_cnt == LAST_NODE) ? '0 : node_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
